// File: rtl/reg_pipe_stage.sv
// Generic valid/ready pipeline stage register with optional skid slot,
// synchronous flush and a saturating back-pressure stall counter.
module reg_pipe_stage #(
  parameter int                DATA_W  = 96,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit                SKID    = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // main always holds the older payload; skid only fills under back-pressure
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept && pop: begin
              main_d = in_data;
            end
            !accept && pop: begin
              main_d  = RST_VAL;
              state_d = EMPTY;
            end
            accept && !pop: begin
              if (SKID) begin
                skid_d  = in_data;
                state_d = FULL;
              end
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = RST_VAL;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_VAL;
          skid_d  = RST_VAL;
        end
      endcase
    end
  end

  // with a skid slot in_ready depends only on state, never on out_ready
  always_comb begin
    out_valid = (state_q != EMPTY);
    if (SKID) begin
      in_ready = (state_q != FULL);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    accept = in_valid && in_ready;
    pop    = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready
                 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_pipe_stage.sv
// Random scoreboard bench for reg_pipe_stage: a skid instance and a
// single-entry instance share stimulus, each with its own reference queue.
module tb_reg_pipe_stage;

  localparam int             DW = 32;
  localparam logic [DW-1:0]  RV = 32'h0000_0013;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [3:0]    a_cnt;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_cnt;

  always #5 clk = ~clk;

  reg_pipe_stage #(
    .DATA_W (DW),
    .RST_VAL(RV),
    .SKID   (1'b1),
    .CNT_W  (4)
  ) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_data  (in_data),
    .out_valid(a_out_valid),
    .out_ready(out_ready),
    .out_data (a_out_data),
    .occupancy(a_occ),
    .stall_cnt(a_cnt)
  );

  reg_pipe_stage #(
    .DATA_W (DW),
    .RST_VAL(RV),
    .SKID   (1'b0),
    .CNT_W  (16)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (b_in_ready),
    .in_data  (in_data),
    .out_valid(b_out_valid),
    .out_ready(out_ready),
    .out_data (b_out_data),
    .occupancy(b_occ),
    .stall_cnt(b_cnt)
  );

  int            errs   = 0;
  int            checks = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            sa = 0;
  int            sb = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(string nm, bit skid, int occ, int stall,
                           logic ir, logic ov, logic [DW-1:0] od,
                           logic [1:0] oc, int cnt);
    bit exp_ir;
    exp_ir = skid ? (occ < 2) : (occ == 0 || out_ready);
    chk({nm, " occupancy"}, 32'(oc), 32'(occ));
    chk({nm, " out_valid"}, 32'(ov), 32'(occ != 0));
    chk({nm, " in_ready"}, 32'(ir), 32'(exp_ir));
    if (occ == 0) chk({nm, " bubble data"}, od, RV);
    chk({nm, " stall_cnt"}, 32'(cnt), 32'(stall));
  endtask

  task automatic check_reset(string nm, logic ir, logic ov,
                             logic [DW-1:0] od, logic [1:0] oc, int cnt);
    chk({nm, " rst out_valid"}, 32'(ov), 32'd0);
    chk({nm, " rst out_data"}, od, RV);
    chk({nm, " rst occupancy"}, 32'(oc), 32'd0);
    chk({nm, " rst in_ready"}, 32'(ir), 32'd1);
    chk({nm, " rst stall_cnt"}, 32'(cnt), 32'd0);
  endtask

  // one clock of stimulus; percentages for valid, ready and flush
  task automatic cycle(int pv, int pr, int pf, bit rst);
    bit acc_a, acc_b;
    int occ_a, occ_b;
    @(negedge clk);
    rst_n     = !rst;
    in_valid  = ($urandom_range(99) < pv);
    in_data   = in_valid ? $urandom : 'x;
    out_ready = ($urandom_range(99) < pr);
    flush     = ($urandom_range(99) < pf);
    #1;
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (rst) begin
      check_reset("A", a_in_ready, a_out_valid, a_out_data, a_occ,
                  int'(a_cnt));
      check_reset("B", b_in_ready, b_out_valid, b_out_data, b_occ,
                  int'(b_cnt));
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
    end else begin
      occ_a = qa.size();
      occ_b = qb.size();
      check_dut("A", 1'b1, occ_a, sa, a_in_ready, a_out_valid,
                a_out_data, a_occ, int'(a_cnt));
      check_dut("B", 1'b0, occ_b, sb, b_in_ready, b_out_valid,
                b_out_data, b_occ, int'(b_cnt));
      acc_a = in_valid && (occ_a < 2);
      acc_b = in_valid && (occ_b == 0 || out_ready);
      if (occ_a != 0 && !out_ready && sa < 15) sa++;
      if (occ_b != 0 && !out_ready && sb < 65535) sb++;
    end
    @(posedge clk);
    if (!rst) begin
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (acc_a) qa.push_back(in_data);
        if (acc_b) qb.push_back(in_data);
      end
    end
  endtask

  // monitor: pops the expected payload on every output handshake
  always @(negedge clk) begin
    #2;
    if (rst_n && !flush) begin
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL A unexpected output: got %0h expected none",
                   a_out_data);
        end else begin
          chk("A data", a_out_data, qa.pop_front());
        end
      end
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL B unexpected output: got %0h expected none",
                   b_out_data);
        end else begin
          chk("B data", b_out_data, qb.pop_front());
        end
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 1'b1);
    repeat (40) cycle(100, 100, 0, 1'b0);
    repeat (40) cycle(70, 20, 0, 1'b0);
    repeat (3) cycle(100, 0, 0, 1'b0);
    cycle(0, 0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cycle(60, 60, 8, (i % 97) == 96);
    end
    repeat (3) cycle(100, 0, 0, 1'b0);
    cycle(100, 0, 100, 1'b0);
    cycle(0, 100, 0, 1'b0);
    repeat (20) cycle(100, 0, 0, 1'b0);
    cycle(0, 0, 100, 1'b0);
    cycle(0, 0, 0, 1'b0);
    repeat (200) cycle(80, 50, 3, 1'b0);
    cycle(0, 100, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
